// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential ROM reads, buffers the returned
// instructions in a small prefetch FIFO and hands them to the core through a
// valid/ready handshake. A redirect from the core flushes buffered and
// in-flight fetches and restarts fetching at the new address.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [CNT_W-1:0]  count_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

  logic [CNT_W-1:0]  occupancy_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              head_valid_s;

  // Issue / push / pop decisions; a redirect suppresses all three so that
  // nothing fetched before it can reach the FIFO or be consumed.
  always_comb begin
    occupancy_s  = count_r + CNT_W'(inflight_r);
    head_valid_s = (count_r != CNT_W'(0));
    issue_s      = !reset && !redirect && (occupancy_s < CNT_W'(DEPTH));
    push_s       = inflight_r && !redirect;
    pop_s        = head_valid_s && ir_ready && !redirect;
  end

  // Control state: fetch PC, in-flight tracking, FIFO pointers and fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= '0;
      count_r       <= '0;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      head_r        <= '0;
      tail_r        <= '0;
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc;
      count_r       <= '0;
      inflight_r    <= 1'b0;
      head_r        <= '0;
      tail_r        <= '0;
    end else begin
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + ADDR_W'(1);
        inflight_pc_r <= fetch_pc_r;
      end
      inflight_r <= issue_s;
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // FIFO storage: the ROM response and the address it was fetched from.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      data_mem_r[tail_r] <= mem_rdata;
      pc_mem_r[tail_r]   <= inflight_pc_r;
    end
  end

  // Outputs: head of FIFO shown directly from storage, zeroed when not valid.
  always_comb begin
    mem_req  = issue_s;
    mem_addr = fetch_pc_r;
    fetch_pc = fetch_pc_r;
    ir_valid = head_valid_s && !reset;
    if (ir_valid) begin
      ir    = data_mem_r[head_r];
      ir_pc = pc_mem_r[head_r];
    end else begin
      ir    = '0;
      ir_pc = '0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a queue-based reference model.
module tb_instr_fetch;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ir_ready = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = 8'h00;
  logic [DW-1:0] mem_rdata = 8'h00;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic [AW-1:0] fetch_pc;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a + 8'h10;
  endfunction

  // Synchronous ROM: data for a request appears the cycle after it.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= rom(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched addresses still owed to the core.
  logic [AW-1:0] mq[$];
  bit            live = 1'b0;
  bit            m_infl = 1'b0;
  logic [AW-1:0] m_ipc = 8'h00;
  logic [AW-1:0] m_fpc = 8'h00;
  bit            exp_valid;
  bit            exp_req;

  // Compare DUT against the model mid-cycle, then advance the model across
  // the coming rising edge using the inputs that edge will see.
  always @(negedge clk) begin
    exp_valid = !reset && (mq.size() != 0);
    exp_req   = !reset && !redirect && ((mq.size() + int'(m_infl)) < DEPTH);
    if (live) begin
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("mem_addr", 32'(mem_addr), 32'(m_fpc));
      chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
      chk("ir_valid", 32'(ir_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("ir", 32'(ir), 32'(rom(mq[0])));
        chk("ir_pc", 32'(ir_pc), 32'(mq[0]));
      end else if (reset) begin
        chk("ir_in_reset", 32'(ir), 32'h0);
        chk("ir_pc_in_reset", 32'(ir_pc), 32'h0);
      end
    end
    if (reset) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = 8'h00;
      live   = 1'b1;
    end else if (live) begin
      if (redirect) begin
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = redirect_pc;
      end else begin
        if (mq.size() != 0 && ir_ready) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_ipc);
        m_infl = exp_req;
        if (exp_req) begin
          m_ipc = m_fpc;
          m_fpc = m_fpc + 8'd1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset values
    tick(1);
    @(negedge clk);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    tick(1);
    reset = 1'b0;

    // Streaming after release: 2-cycle first latency
    @(negedge clk);
    chk("t1_c0_req", 32'(mem_req), 32'h1);
    chk("t1_c0_addr", 32'(mem_addr), 32'h00);
    chk("t1_c0_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    chk("t1_c1_addr", 32'(mem_addr), 32'h01);
    chk("t1_c1_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    chk("t1_c2_valid", 32'(ir_valid), 32'h1);
    chk("t1_c2_ir", 32'(ir), 32'h10);
    chk("t1_c2_pc", 32'(ir_pc), 32'h00);
    @(negedge clk);
    chk("t1_c3_ir", 32'(ir), 32'h11);

    // Redirect while fetching address 05
    tick(2);
    chk("t3_addr_before", 32'(mem_addr), 32'h05);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    chk("t3_req_in_redirect", 32'(mem_req), 32'h0);
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_addr_after", 32'(mem_addr), 32'h40);
    chk("t3_req_after", 32'(mem_req), 32'h1);
    chk("t3_empty_after", 32'(ir_valid), 32'h0);
    tick(2);
    @(negedge clk);
    chk("t3_first_ir", 32'(ir), 32'h50);
    chk("t3_first_pc", 32'(ir_pc), 32'h40);

    // Two entries buffered, then push and pop together for several cycles
    tick(1);
    ir_ready = 1'b0;
    tick(1);
    ir_ready = 1'b1;
    tick(6);

    // Redirect near the top of the address space: PC wraps FF -> 00
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    tick(1);
    redirect = 1'b0;
    tick(2);
    @(negedge clk);
    chk("t4_pc_fe", 32'(ir_pc), 32'hFE);
    chk("t4_ir_fe", 32'(ir), 32'h0E);
    @(negedge clk);
    chk("t4_pc_ff", 32'(ir_pc), 32'hFF);
    @(negedge clk);
    chk("t4_pc_00", 32'(ir_pc), 32'h00);
    chk("t4_ir_00", 32'(ir), 32'h10);
    @(negedge clk);
    chk("t4_pc_01", 32'(ir_pc), 32'h01);

    // Back-to-back redirects: the last one wins
    tick(1);
    redirect = 1'b1;
    redirect_pc = 8'h20;
    tick(1);
    redirect_pc = 8'h30;
    tick(1);
    redirect = 1'b0;
    tick(2);
    @(negedge clk);
    chk("b2b_pc", 32'(ir_pc), 32'h30);
    chk("b2b_ir", 32'(ir), 32'h40);

    // Core stalled: FIFO fills with exactly four entries
    tick(1);
    reset = 1'b1;
    ir_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(8);
    @(negedge clk);
    chk("t2_full_req", 32'(mem_req), 32'h0);
    chk("t2_full_fetch_pc", 32'(fetch_pc), 32'h04);
    chk("t2_full_pc", 32'(ir_pc), 32'h00);
    chk("t2_full_ir", 32'(ir), 32'h10);
    tick(1);
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    @(negedge clk);
    chk("t2_refill_req", 32'(mem_req), 32'h1);
    chk("t2_refill_addr", 32'(mem_addr), 32'h04);
    chk("t2_new_head", 32'(ir_pc), 32'h01);

    // Reset while full with a request in flight
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_req_in_reset", 32'(mem_req), 32'h0);
    tick(1);
    reset = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(ir_valid), 32'h0);
    chk("t6_fetch_pc", 32'(fetch_pc), 32'h00);
    @(negedge clk);
    chk("t6_c1_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    chk("t6_c2_ir", 32'(ir), 32'h10);
    chk("t6_c2_pc", 32'(ir_pc), 32'h00);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
